argmax_classifier: RTL

Sequential argmax stage directly downstream of the network top: on the top's `done` pulse it snapshots the `OUTPUT_SIZE` signed logits, scans them one per cycle, and presents the winning class index and score on a valid/ready output. It decouples the network (which may start a new inference) from the result consumer (UART/LED/host register).

---
 rtl/argmax_classifier.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/argmax_classifier.sv
// argmax_classifier: snapshots NUM_CLASSES signed scores on start, scans one
// per cycle and presents the winning index/score on a valid/ready output.
// Optional feature macro: ARGMAX_MARGIN_EN (adds runner-up index and margin).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             capture pulse (from network done)
//   in_scores         NUM_CLASSES x DATA_WIDTH signed scores
//   busy              high while scanning
//   out_valid/ready   result handshake
//   out_class/score   argmax index and value
//   overrun           sticky: a start was dropped
//   out_second_class  runner-up index          (ARGMAX_MARGIN_EN only)
//   out_margin        best - runner-up, DW+1b   (ARGMAX_MARGIN_EN only)
module argmax_classifier #(
    parameter  int NUM_CLASSES = 10,
    parameter  int DATA_WIDTH  = 32,
    localparam int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_scores [NUM_CLASSES],
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_class,
    output logic [DATA_WIDTH-1:0] out_score,
`ifdef ARGMAX_MARGIN_EN
    output logic [IDX_WIDTH-1:0]  out_second_class,
    output logic [DATA_WIDTH:0]   out_margin,
`endif
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH-1:0] ONE  = IDX_WIDTH'(1);

    state_t                state_q;
    logic                  busy_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] best_q;
    logic [IDX_WIDTH-1:0]  best_idx_q;
    logic [DATA_WIDTH-1:0] res_score_q;
    logic [IDX_WIDTH-1:0]  res_class_q;
    logic [DATA_WIDTH-1:0] buf_q [NUM_CLASSES];

    logic                  cap;
    logic [DATA_WIDTH-1:0] cur;
    logic                  gt_best;
    logic [DATA_WIDTH-1:0] best_d;
    logic [IDX_WIDTH-1:0]  best_idx_d;

`ifdef ARGMAX_MARGIN_EN
    logic [DATA_WIDTH-1:0] sec_q;
    logic [IDX_WIDTH-1:0]  sec_idx_q;
    logic [IDX_WIDTH-1:0]  res_sec_idx_q;
    logic [DATA_WIDTH:0]   res_margin_q;
    logic                  gt_sec;
    logic [DATA_WIDTH-1:0] sec_d;
    logic [IDX_WIDTH-1:0]  sec_idx_d;
    logic [DATA_WIDTH:0]   margin_d;
`endif

    // Capture happens from IDLE, or from HOLD on the handshake edge.
    assign cap = start &&
                 ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

    always_comb begin
        cur        = buf_q[idx_q];
        gt_best    = $signed(cur) > $signed(best_q);
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (gt_best) begin
            best_d     = cur;
            best_idx_d = idx_q;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    // Runner-up is seeded on the first compare regardless of its value.
    always_comb begin
        gt_sec    = $signed(cur) > $signed(sec_q);
        sec_d     = sec_q;
        sec_idx_d = sec_idx_q;
        if (gt_best) begin
            sec_d     = best_q;
            sec_idx_d = best_idx_q;
        end else if (gt_sec || (idx_q == ONE)) begin
            sec_d     = cur;
            sec_idx_d = idx_q;
        end
        // Extra bit keeps max - min from wrapping.
        margin_d = {best_d[DATA_WIDTH-1], best_d}
                 - {sec_d[DATA_WIDTH-1], sec_d};
    end
`endif

    // Snapshot buffer: contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (cap) begin
            buf_q <= in_scores;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            idx_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            res_score_q <= '0;
            res_class_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            sec_q         <= '0;
            sec_idx_q     <= '0;
            res_sec_idx_q <= '0;
            res_margin_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= SCAN;
                        busy_q     <= 1'b1;
                        best_q     <= in_scores[0];
                        best_idx_q <= '0;
                        idx_q      <= ONE;
                    end
                end
                SCAN: begin
                    if (start) begin
                        overrun_q <= 1'b1;
                    end
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
`ifdef ARGMAX_MARGIN_EN
                    sec_q     <= sec_d;
                    sec_idx_q <= sec_idx_d;
`endif
                    idx_q <= idx_q + ONE;
                    if (idx_q == LAST) begin
                        state_q     <= HOLD;
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        res_score_q <= best_d;
                        res_class_q <= best_idx_d;
`ifdef ARGMAX_MARGIN_EN
                        res_sec_idx_q <= sec_idx_d;
                        res_margin_q  <= margin_d;
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (start) begin
                            state_q    <= SCAN;
                            busy_q     <= 1'b1;
                            best_q     <= in_scores[0];
                            best_idx_q <= '0;
                            idx_q      <= ONE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (start) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign out_class = res_class_q;
    assign out_score = res_score_q;
`ifdef ARGMAX_MARGIN_EN
    assign out_second_class = res_sec_idx_q;
    assign out_margin       = res_margin_q;
`endif

endmodule
